// File: rtl/pb_multi_ch_job_scheduler_if.sv
// Request/port bundle between the job scheduler, its requesting channels and the packet builder.
// master = channel/packet-builder side, slave = scheduler side.
interface pb_multi_ch_job_scheduler_if #(
    parameter int NUM_CH = 4,
    parameter int ADDR_W = 32
);
    localparam int CH_W = $clog2(NUM_CH);

    logic [NUM_CH-1:0]        ch_req_valid;
    logic [NUM_CH-1:0]        ch_req_ready;
    logic [NUM_CH*ADDR_W-1:0] ch_addr_in;
    logic [NUM_CH*4-1:0]      ch_byte_cnt;
    logic [NUM_CH*4-1:0]      ch_pkt_type;
    logic [NUM_CH-1:0]        ch_ecc_en;
    logic [NUM_CH-1:0]        ch_crc_en;

    logic                     pb_start;
    logic [ADDR_W-1:0]        pb_addr_in;
    logic [3:0]               pb_byte_cnt;
    logic [3:0]               pb_pkt_type;
    logic                     pb_ecc_en;
    logic                     pb_crc_en;
    logic                     pb_busy;
    logic                     pb_irq;

    logic                     done_valid;
    logic [CH_W-1:0]          done_ch;
    logic                     done_timeout;

    modport master (
        output ch_req_valid, ch_addr_in, ch_byte_cnt, ch_pkt_type, ch_ecc_en, ch_crc_en,
        output pb_busy, pb_irq,
        input  ch_req_ready, pb_start, pb_addr_in, pb_byte_cnt, pb_pkt_type, pb_ecc_en, pb_crc_en,
        input  done_valid, done_ch, done_timeout
    );

    modport slave (
        input  ch_req_valid, ch_addr_in, ch_byte_cnt, ch_pkt_type, ch_ecc_en, ch_crc_en,
        input  pb_busy, pb_irq,
        output ch_req_ready, pb_start, pb_addr_in, pb_byte_cnt, pb_pkt_type, pb_ecc_en, pb_crc_en,
        output done_valid, done_ch, done_timeout
    );
endinterface

// File: rtl/pb_multi_ch_job_scheduler.sv
// Round-robin scheduler of NUM_CH channel jobs onto one packet-builder port; pb_start 1 cycle after accept,
// done_valid the cycle after irq/timeout. Only one job in flight: all ch_req_ready stay low until IDLE.
module pb_multi_ch_job_scheduler #(
    parameter int NUM_CH  = 4,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic                      clk,
    input  logic                      rst_n,
    pb_multi_ch_job_scheduler_if.slave bus
);
    localparam int CH_W = $clog2(NUM_CH);
    localparam int TO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT_BUSY,
        S_RUN,
        S_DONE
    } state_t;

    state_t            state_q;
    logic [CH_W-1:0]   rr_ptr_q;
    logic [CH_W-1:0]   id_q;
    logic [TO_W-1:0]   to_cnt_q;
    logic              pb_start_q;
    logic [ADDR_W-1:0] pb_addr_q;
    logic [3:0]        pb_byte_cnt_q;
    logic [3:0]        pb_pkt_type_q;
    logic              pb_ecc_en_q;
    logic              pb_crc_en_q;
    logic              done_valid_q;
    logic [CH_W-1:0]   done_ch_q;
    logic              done_timeout_q;

    logic              win_vld;
    logic [CH_W-1:0]   win_id;
    logic [NUM_CH-1:0] ready;
    logic              to_hit;
    int                idx;

    // First valid channel scanning upward from rr_ptr with wrap-around.
    always_comb begin
        win_vld = 1'b0;
        win_id  = '0;
        idx     = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!win_vld && bus.ch_req_valid[idx]) begin
                win_vld = 1'b1;
                win_id  = CH_W'(idx);
            end
        end
    end

    // Gated by rst_n so the grant drops the instant reset asserts, not at the next edge.
    always_comb begin
        ready = '0;
        if (rst_n && state_q == S_IDLE && win_vld) ready[win_id] = 1'b1;
    end

    assign to_hit = (to_cnt_q == TO_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            rr_ptr_q       <= '0;
            id_q           <= '0;
            to_cnt_q       <= '0;
            pb_start_q     <= 1'b0;
            pb_addr_q      <= '0;
            pb_byte_cnt_q  <= '0;
            pb_pkt_type_q  <= '0;
            pb_ecc_en_q    <= 1'b0;
            pb_crc_en_q    <= 1'b0;
            done_valid_q   <= 1'b0;
            done_ch_q      <= '0;
            done_timeout_q <= 1'b0;
        end else begin
            pb_start_q   <= 1'b0;
            done_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (win_vld) begin
                        id_q          <= win_id;
                        rr_ptr_q      <= (win_id == CH_W'(NUM_CH - 1)) ? '0 : win_id + 1'b1;
                        pb_addr_q     <= bus.ch_addr_in[win_id*ADDR_W +: ADDR_W];
                        pb_byte_cnt_q <= bus.ch_byte_cnt[win_id*4 +: 4];
                        pb_pkt_type_q <= bus.ch_pkt_type[win_id*4 +: 4];
                        pb_ecc_en_q   <= bus.ch_ecc_en[win_id];
                        pb_crc_en_q   <= bus.ch_crc_en[win_id];
                        pb_start_q    <= 1'b1;
                        state_q       <= S_START;
                    end
                end
                S_START: begin
                    to_cnt_q <= '0;
                    state_q  <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY, S_RUN: begin
                    to_cnt_q <= to_cnt_q + 1'b1;
                    // irq outranks a coincident timeout; busy falling in RUN is deliberately ignored.
                    if (bus.pb_irq) begin
                        done_valid_q   <= 1'b1;
                        done_ch_q      <= id_q;
                        done_timeout_q <= 1'b0;
                        state_q        <= S_DONE;
                    end else if (to_hit) begin
                        done_valid_q   <= 1'b1;
                        done_ch_q      <= id_q;
                        done_timeout_q <= 1'b1;
                        state_q        <= S_DONE;
                    end else if (state_q == S_WAIT_BUSY && bus.pb_busy) begin
                        state_q <= S_RUN;
                    end
                end
                S_DONE: begin
                    done_timeout_q <= 1'b0;
                    state_q        <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.ch_req_ready = ready;
    assign bus.pb_start     = pb_start_q;
    assign bus.pb_addr_in   = pb_addr_q;
    assign bus.pb_byte_cnt  = pb_byte_cnt_q;
    assign bus.pb_pkt_type  = pb_pkt_type_q;
    assign bus.pb_ecc_en    = pb_ecc_en_q;
    assign bus.pb_crc_en    = pb_crc_en_q;
    assign bus.done_valid   = done_valid_q;
    assign bus.done_ch      = done_ch_q;
    assign bus.done_timeout = done_timeout_q;
endmodule

// File: tb/tb_pb_multi_ch_job_scheduler.sv
// Directed plus randomized jobs against a round-robin/timeout reference model; inputs change on negedge.
module tb_pb_multi_ch_job_scheduler;
    localparam int NCH = 4;
    localparam int AW  = 32;
    localparam int TMO = 16;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    int   rr_m  = 0;

    always #5 clk = ~clk;

    pb_multi_ch_job_scheduler_if #(.NUM_CH(NCH), .ADDR_W(AW)) bus ();

    pb_multi_ch_job_scheduler #(.NUM_CH(NCH), .ADDR_W(AW), .TIMEOUT(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Round-robin rule: first requesting channel at or after ptr, wrapping.
    function automatic int pick(input logic [NCH-1:0] v, input int ptr);
        for (int i = 0; i < NCH; i++)
            if (v[(ptr + i) % NCH]) return (ptr + i) % NCH;
        return -1;
    endfunction

    task automatic rand_fields();
        for (int c = 0; c < NCH; c++) begin
            bus.ch_addr_in[c*AW +: AW] = $urandom;
            bus.ch_byte_cnt[c*4 +: 4]  = 4'($urandom);
            bus.ch_pkt_type[c*4 +: 4]  = 4'($urandom);
            bus.ch_ecc_en[c]           = 1'($urandom);
            bus.ch_crc_en[c]           = 1'($urandom);
        end
    endtask

    // Called at a negedge with the DUT idle. irq_at/busy window are offsets from WAIT_BUSY entry.
    task automatic do_job(input int irq_at, input int busy_from, input int busy_to,
                          input bit drop, input string tag);
        int w, d;
        bit exp_to;
        logic [AW-1:0] e_addr;
        logic [3:0] e_cnt, e_typ;
        logic e_ecc, e_crc;
        #1;
        w = pick(bus.ch_req_valid, rr_m);
        chk({tag, "_grant"}, 64'(bus.ch_req_ready), (w < 0) ? 64'd0 : (64'd1 << w));
        if (w < 0) return;
        e_addr = bus.ch_addr_in[w*AW +: AW];
        e_cnt  = bus.ch_byte_cnt[w*4 +: 4];
        e_typ  = bus.ch_pkt_type[w*4 +: 4];
        e_ecc  = bus.ch_ecc_en[w];
        e_crc  = bus.ch_crc_en[w];
        rr_m   = (w + 1) % NCH;
        @(negedge clk);
        if (drop) bus.ch_req_valid[w] = 1'b0;
        chk({tag, "_start"}, {bus.pb_start, |bus.ch_req_ready}, 2'b10);
        chk({tag, "_fields"}, {bus.pb_addr_in, bus.pb_byte_cnt, bus.pb_pkt_type, bus.pb_ecc_en, bus.pb_crc_en},
            {e_addr, e_cnt, e_typ, e_ecc, e_crc});
        rand_fields();
        if (irq_at >= 0 && irq_at < TMO) begin
            d = irq_at + 1;
            exp_to = 1'b0;
        end else begin
            d = TMO;
            exp_to = 1'b1;
        end
        for (int k = 0; k < d; k++) begin
            @(negedge clk);
            chk({tag, "_wait"}, {bus.done_valid, bus.pb_start, |bus.ch_req_ready}, 3'b000);
            bus.pb_irq  = (k == irq_at);
            bus.pb_busy = (k >= busy_from && k < busy_to);
        end
        @(negedge clk);
        bus.pb_irq  = 1'b0;
        bus.pb_busy = 1'b0;
        chk({tag, "_done"}, {bus.done_valid, bus.pb_start, |bus.ch_req_ready}, 3'b100);
        chk({tag, "_done_ch"}, 64'(bus.done_ch), 64'(w));
        chk({tag, "_timeout"}, 64'(bus.done_timeout), 64'(exp_to));
        chk({tag, "_held"}, {bus.pb_addr_in, bus.pb_byte_cnt, bus.pb_pkt_type}, {e_addr, e_cnt, e_typ});
        @(negedge clk);
        chk({tag, "_idle"}, {bus.done_valid, bus.done_timeout, bus.pb_addr_in}, {2'b00, e_addr});
    endtask

    initial begin
        int w;
        rst_n            = 1'b0;
        bus.ch_req_valid = '0;
        bus.ch_addr_in   = '0;
        bus.ch_byte_cnt  = '0;
        bus.ch_pkt_type  = '0;
        bus.ch_ecc_en    = '0;
        bus.ch_crc_en    = '0;
        bus.pb_busy      = 1'b0;
        bus.pb_irq       = 1'b0;
        #12;
        chk("rst_ctl", {bus.pb_start, bus.done_valid, bus.done_timeout, bus.ch_req_ready}, '0);
        chk("rst_pb", {bus.pb_addr_in, bus.pb_byte_cnt, bus.pb_pkt_type, bus.pb_ecc_en, bus.pb_crc_en,
                       bus.done_ch}, '0);
        @(negedge clk);
        rst_n = 1'b1;

        // All channels requesting continuously: 0,1,2,3,0.
        bus.ch_req_valid = 4'hF;
        rand_fields();
        for (int j = 0; j < 5; j++) do_job(2, 0, 2, 1'b0, "t2");

        // Single ch1 job with busy for three cycles then irq.
        bus.ch_req_valid = 4'b0010;
        bus.ch_addr_in[1*AW +: AW] = 32'h100;
        bus.ch_byte_cnt[1*4 +: 4]  = 4'd5;
        bus.ch_pkt_type[1*4 +: 4]  = 4'd2;
        bus.ch_ecc_en[1] = 1'b1;
        bus.ch_crc_en[1] = 1'b0;
        do_job(3, 0, 3, 1'b1, "t1");

        // Fast job: irq right after START, busy never seen.
        bus.ch_req_valid = 4'b0100;
        do_job(0, 0, 0, 1'b1, "t3");

        // Timeout with busy held, then irq on the final counted cycle.
        bus.ch_req_valid = 4'b0001;
        do_job(-1, 0, 100, 1'b1, "t4to");
        bus.ch_req_valid = 4'b0001;
        do_job(TMO - 1, 0, 100, 1'b1, "t4irq");
        // Busy drops in RUN without irq: must keep waiting.
        bus.ch_req_valid = 4'b1000;
        do_job(9, 1, 3, 1'b1, "busydrop");

        // Reset while in RUN: everything clears at once, no done pulse, restart from ch0.
        bus.ch_req_valid = 4'b1000;
        #1;
        w = pick(bus.ch_req_valid, rr_m);
        chk("t5_grant", 64'(bus.ch_req_ready), 64'd1 << w);
        @(negedge clk);
        bus.ch_req_valid = 4'b1001;
        @(negedge clk);
        bus.pb_busy = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_ctl", {bus.pb_start, bus.done_valid, bus.ch_req_ready}, '0);
        chk("t5_rst_pb", {bus.pb_addr_in, bus.pb_byte_cnt, bus.done_ch}, '0);
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk("t5_hold", {bus.done_valid, bus.ch_req_ready}, '0);
        end
        bus.pb_busy = 1'b0;
        rst_n = 1'b1;
        rr_m  = 0;
        do_job(4, 0, 2, 1'b1, "t5_after");

        // Randomized jobs.
        for (int j = 0; j < 25; j++) begin
            int irq, bf, bt;
            bus.ch_req_valid = 4'($urandom_range(1, 15));
            irq = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, TMO + 2));
            bf  = int'($urandom_range(0, 3));
            bt  = bf + int'($urandom_range(0, 8));
            do_job(irq, bf, bt, 1'($urandom), "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
